// File: rtl/gauss_window_scheduler.sv
// rtl/gauss_window_scheduler.sv - round-robin window issue to a fixed-latency filter with tagged, credit-limited result FIFO
module gauss_window_scheduler #(
  parameter int WIN_W = 686,
  parameter int RES_W = 26,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIN_W-1:0] req0_window,
  input  logic [15:0]      req0_addr,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIN_W-1:0] req1_window,
  input  logic [15:0]      req1_addr,
  output logic             f_win_valid,
  output logic [WIN_W-1:0] f_win_value,
  input  logic             f_res_valid,
  input  logic [RES_W-1:0] f_res_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_value,
  output logic [15:0]      out_addr,
  output logic             out_src,
  output logic             busy,
  output logic             err_mismatch
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(LAT + DEPTH + 2);
  localparam int FE_W = 1 + 16 + RES_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rr_ptr;
  logic             r_iss_valid;
  logic             r_iss_src;
  logic [15:0]      r_iss_addr;
  logic [WIN_W-1:0] r_f_win_value;
  logic             r_tag_v    [LAT];
  logic             r_tag_src  [LAT];
  logic [15:0]      r_tag_addr [LAT];
  logic [FE_W-1:0]  r_fifo_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_count_next;
  logic             w_credit;
  logic             w_issue_ok;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_tail_v;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_nempty;
  logic [FE_W-1:0]  w_head;

  // Pending issue register plus every live tag; all of these will land in the FIFO.
  always_comb begin
    w_inflight = CW'(r_iss_valid);
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + CW'(r_tag_v[i]);
    end
  end

  assign w_credit      = (w_inflight + r_count) < CW'(DEPTH);
  assign w_tail_v      = r_tag_v[LAT-1];
  assign w_push        = w_tail_v & f_res_valid;
  assign w_fifo_nempty = (r_count != '0);
  assign w_pop         = w_fifo_nempty & out_ready;
  assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_accept      = w_grant0 | w_grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Leaving DRAIN looks at the post-pop count so busy drops right after the last pop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_next = S_RUN;
      S_RUN:   if (!en) w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (en)                                          w_state_next = S_RUN;
        else if (w_inflight == '0 && w_count_next == '0) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    w_issue_ok = (r_state == S_RUN) & en & w_credit;
    w_grant0   = w_issue_ok & req0_valid & (~req1_valid | ~r_rr_ptr);
    w_grant1   = w_issue_ok & req1_valid & (~req0_valid |  r_rr_ptr);
    req0_ready = w_grant0;
    req1_ready = w_grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= 1'b0;
      r_iss_valid   <= 1'b0;
      r_iss_src     <= 1'b0;
      r_iss_addr    <= '0;
      r_f_win_value <= '0;
    end else begin
      r_iss_valid <= w_accept;
      if (w_accept) begin
        r_rr_ptr      <= ~w_grant1;
        r_iss_src     <= w_grant1;
        r_iss_addr    <= w_grant1 ? req1_addr : req0_addr;
        r_f_win_value <= w_grant1 ? req1_window : req0_window;
      end
    end
  end

  // Tag enters stage 0 the cycle after f_win_valid, so the tail meets the result after LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_tag_v[i]    <= 1'b0;
        r_tag_src[i]  <= 1'b0;
        r_tag_addr[i] <= '0;
      end
    end else begin
      r_tag_v[0]    <= r_iss_valid;
      r_tag_src[0]  <= r_iss_src;
      r_tag_addr[0] <= r_iss_addr;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_src[i]  <= r_tag_src[i-1];
        r_tag_addr[i] <= r_tag_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_err <= 1'b0;
    else if (w_tail_v ^ f_res_valid) r_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {r_tag_src[LAT-1], r_tag_addr[LAT-1], f_res_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Payload is forced to zero while empty so the unreset storage never reaches the outputs.
  assign w_head       = w_fifo_nempty ? r_fifo_mem[r_rd_ptr] : '0;
  assign out_valid    = w_fifo_nempty;
  assign out_src      = w_head[FE_W-1];
  assign out_addr     = w_head[FE_W-2 -: 16];
  assign out_value    = w_head[RES_W-1:0];
  assign f_win_valid  = r_iss_valid;
  assign f_win_value  = r_f_win_value;
  assign err_mismatch = r_err;

endmodule
